e_mdu: RTL and testbench

- Multi-cycle multiply/divide unit in the E stage, alongside the combinational ALU.
- Executes mult/multu/div/divu and owns the architectural HI/LO registers; services mfhi/mflo/mthi/mtlo.
- Exposes a busy flag so hazard logic stalls D-stage md instructions while an operation is in flight.
- Result path back into the pipeline is the mf* read value, which E-stage muxes select alongside out_aluout.

---
 rtl/e_mdu_pkg.sv | 31 +++
 rtl/e_mdu_if.sv | 25 ++
 rtl/e_mdu.sv | 111 +++++++++++
 tb/tb_e_mdu.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/e_mdu_pkg.sv
// rtl/e_mdu_pkg.sv - MDU operation codes, default latencies and signed-division fix-up
// Shared by the MDU, its interface and the testbench.
package e_mdu_pkg;

   localparam logic [3:0] MDU_none  = 4'd0;
   localparam logic [3:0] MDU_mult  = 4'd1;
   localparam logic [3:0] MDU_multu = 4'd2;
   localparam logic [3:0] MDU_div   = 4'd3;
   localparam logic [3:0] MDU_divu  = 4'd4;
   localparam logic [3:0] MDU_mfhi  = 4'd5;
   localparam logic [3:0] MDU_mflo  = 4'd6;
   localparam logic [3:0] MDU_mthi  = 4'd7;
   localparam logic [3:0] MDU_mtlo  = 4'd8;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   typedef enum logic {S_IDLE, S_BUSY} mdu_state_t;

   // Turns a magnitude quotient/remainder back into signed form: the quotient
   // truncates toward zero and the remainder follows the dividend's sign.
   function automatic logic [63:0] sdiv_fixup(input logic a_neg, input logic b_neg,
                                              input logic [31:0] qu, input logic [31:0] ru);
      logic [31:0] q;
      logic [31:0] r;
      q = (a_neg ^ b_neg) ? (~qu + 32'd1) : qu;
      r = a_neg ? (~ru + 32'd1) : ru;
      return {r, q};
   endfunction

endpackage

// File: rtl/e_mdu_if.sv
// rtl/e_mdu_if.sv - E-stage request/response bundle of the multiply/divide unit
// The pipeline drives the in_* side; the MDU returns busy and the mf* read value.
interface e_mdu_if;
   import e_mdu_pkg::*;

   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic [31:0] in_num1;
   logic [31:0] in_num2;
   logic [3:0]  in_mdop;
   logic        in_start;
   logic        out_busy;
   logic [31:0] out_mdout;

   modport master (
      output in_pc, in_instr, in_num1, in_num2, in_mdop, in_start,
      input  out_busy, out_mdout
   );

   modport slave (
      input  in_pc, in_instr, in_num1, in_num2, in_mdop, in_start,
      output out_busy, out_mdout
   );

endinterface

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - multi-cycle mult/div unit owning HI/LO, with mfhi/mflo/mthi/mtlo
// Results are computed combinationally from latched operands; only the write time is fixed.
module e_mdu
   import e_mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   e_mdu_if.slave md
);

   mdu_state_t  r_state;
   mdu_state_t  w_state_nx;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_nx;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [31:0] w_hi_nx;
   logic [31:0] w_lo_nx;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [3:0]  r_op;
   logic        w_start;
   logic        w_is_md;
   logic        w_is_mul;

   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic        w_sdiv;
   logic [31:0] w_dvd;
   logic [31:0] w_dvs;
   logic [31:0] w_qu;
   logic [31:0] w_ru;
   logic [63:0] w_div_s;

   assign w_is_mul = (md.in_mdop == MDU_mult) || (md.in_mdop == MDU_multu);
   assign w_is_md  = w_is_mul || (md.in_mdop == MDU_div) || (md.in_mdop == MDU_divu);

   assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
   assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

   // One unsigned divider serves both div and divu; div feeds it magnitudes.
   assign w_sdiv  = (r_op == MDU_div);
   assign w_dvd   = (w_sdiv && r_a[31]) ? (~r_a + 32'd1) : r_a;
   assign w_dvs   = (w_sdiv && r_b[31]) ? (~r_b + 32'd1) : r_b;
   assign w_qu    = (w_dvs == 32'd0) ? 32'd0 : (w_dvd / w_dvs);
   assign w_ru    = (w_dvs == 32'd0) ? 32'd0 : (w_dvd % w_dvs);
   assign w_div_s = sdiv_fixup(r_a[31], r_b[31], w_qu, w_ru);

   always_comb begin
      w_cnt_nx = r_cnt;
      w_hi_nx  = r_hi;
      w_lo_nx  = r_lo;
      w_start  = 1'b0;
      if (r_state == S_BUSY) begin
         w_cnt_nx = r_cnt - 16'd1;
         if (r_cnt == 16'd1) begin
            case (r_op)
               MDU_mult:  {w_hi_nx, w_lo_nx} = w_prod_s;
               MDU_multu: {w_hi_nx, w_lo_nx} = w_prod_u;
               MDU_div:   if (r_b != 32'd0) {w_hi_nx, w_lo_nx} = w_div_s;
               MDU_divu:  if (r_b != 32'd0) {w_hi_nx, w_lo_nx} = {w_ru, w_qu};
               default: ;
            endcase
         end
      end else if (md.in_start && w_is_md) begin
         w_start  = 1'b1;
         w_cnt_nx = w_is_mul ? 16'(MULT_CYCLES) : 16'(DIV_CYCLES);
      end else if (!md.in_start && md.in_mdop == MDU_mthi) begin
         w_hi_nx = md.in_num1;
      end else if (!md.in_start && md.in_mdop == MDU_mtlo) begin
         w_lo_nx = md.in_num1;
      end
      w_state_nx = (w_cnt_nx != 16'd0) ? S_BUSY : S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 16'd0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_op    <= MDU_none;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_hi    <= w_hi_nx;
         r_lo    <= w_lo_nx;
         if (w_start) begin
            r_a  <= md.in_num1;
            r_b  <= md.in_num2;
            r_op <= md.in_mdop;
         end
      end
   end

   assign md.out_busy = (r_state == S_BUSY);

   always_comb begin
      case (md.in_mdop)
         MDU_mfhi: md.out_mdout = r_hi;
         MDU_mflo: md.out_mdout = r_lo;
         default:  md.out_mdout = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - scoreboard bench for e_mdu latency, HI/LO results and mt*/mf* access
module tb_e_mdu;
   import e_mdu_pkg::*;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errs;
   logic [63:0] sb_q[$];

   e_mdu_if bus();

   e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s got %h exp %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
      bus.in_mdop = MDU_mfhi;
      #1 hi = bus.out_mdout;
      bus.in_mdop = MDU_mflo;
      #1 lo = bus.out_mdout;
      bus.in_mdop = MDU_none;
      #1;
   endtask

   task automatic mt_op(input logic [3:0] op, input logic [31:0] v);
      bus.in_mdop = op;
      bus.in_num1 = v;
      step();
      bus.in_mdop = MDU_none;
   endtask

   task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp);
      bus.in_mdop  = op;
      bus.in_num1  = a;
      bus.in_num2  = b;
      bus.in_start = 1'b1;
      sb_q.push_back(exp);
      step();
      bus.in_start = 1'b0;
      bus.in_mdop  = MDU_none;
   endtask

   task automatic wait_done(input string tag, input int n);
      int cnt;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [63:0] exp;
      cnt = 0;
      while (bus.out_busy && cnt < 100) begin
         cnt++;
         step();
      end
      check_eq({tag, "_busy_cycles"}, 64'(cnt), 64'(n));
      read_hilo(hi, lo);
      if (sb_q.size() == 0) begin
         check_eq({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
      end else begin
         exp = sb_q.pop_front();
         check_eq({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
         check_eq({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
      end
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int n);
      start_op(op, a, b, exp);
      wait_done(tag, n);
   endtask

   function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic signed [31:0] a32;
      logic signed [31:0] b32;
      logic signed [31:0] q;
      logic signed [31:0] r;
      sa  = $signed(a);
      sb  = $signed(b);
      a32 = $signed(a);
      b32 = $signed(b);
      case (op)
         MDU_mult:  return 64'(sa * sb);
         MDU_multu: return {32'd0, a} * {32'd0, b};
         MDU_div: begin
            q = a32 / b32;
            r = a32 % b32;
            return {32'(r), 32'(q)};
         end
         default:   return {a % b, a / b};
      endcase
   endfunction

   initial begin
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] a;
      logic [31:0] b;
      n_checks = 0;
      n_errs   = 0;
      reset         = 1'b1;
      bus.in_pc     = 32'h0040_0000;
      bus.in_instr  = 32'd0;
      bus.in_num1   = 32'd0;
      bus.in_num2   = 32'd0;
      bus.in_mdop   = MDU_none;
      bus.in_start  = 1'b0;
      step();
      step();
      reset = 1'b0;
      check_eq("reset_busy", 64'(bus.out_busy), 64'd0);
      read_hilo(hi, lo);
      check_eq("reset_hi", 64'(hi), 64'd0);
      check_eq("reset_lo", 64'(lo), 64'd0);

      run_op("mult", MDU_mult, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 5);
      run_op("multu", MDU_multu, 32'hFFFF_FFFE, 32'd3, {32'h0000_0002, 32'hFFFF_FFFA}, 5);
      run_op("div_neg", MDU_div, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10);
      run_op("divu", MDU_divu, 32'd7, 32'd2, {32'd1, 32'd3}, 10);
      run_op("div_ovf", MDU_div, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 10);

      mt_op(MDU_mthi, 32'h11);
      mt_op(MDU_mtlo, 32'h22);
      run_op("divu_zero", MDU_divu, 32'd5, 32'd0, {32'h11, 32'h22}, 10);

      mt_op(MDU_mthi, 32'hDEAD_BEEF);
      bus.in_mdop = MDU_mfhi;
      #1 check_eq("mfhi", 64'(bus.out_mdout), 64'h0000_0000_DEAD_BEEF);
      bus.in_mdop = MDU_none;
      #1 check_eq("mdop_none", 64'(bus.out_mdout), 64'd0);

      // non-md op with in_start must not start anything
      bus.in_mdop  = MDU_mfhi;
      bus.in_start = 1'b1;
      step();
      bus.in_start = 1'b0;
      bus.in_mdop  = MDU_none;
      check_eq("bad_start_busy", 64'(bus.out_busy), 64'd0);

      for (int i = 0; i < 4; i++) begin
         a = $urandom;
         b = $urandom | 32'd1;
         run_op("rnd_mult", MDU_mult, a, b, model(MDU_mult, a, b), 5);
         run_op("rnd_multu", MDU_multu, a, b, model(MDU_multu, a, b), 5);
         if (a == 32'h8000_0000) a = 32'd12345;
         run_op("rnd_div", MDU_div, a, b, model(MDU_div, a, b), 10);
         run_op("rnd_divu", MDU_divu, a, b >> 7, model(MDU_divu, a, b >> 7), 10);
      end

      // reset on busy cycle 3 aborts the mult with no late write
      mt_op(MDU_mthi, 32'h77);
      bus.in_mdop  = MDU_mult;
      bus.in_num1  = 32'd3;
      bus.in_num2  = 32'd4;
      bus.in_start = 1'b1;
      step();
      bus.in_start = 1'b0;
      bus.in_mdop  = MDU_none;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("rst_abort_busy", 64'(bus.out_busy), 64'd0);
      read_hilo(hi, lo);
      check_eq("rst_abort_hi", 64'(hi), 64'd0);
      check_eq("rst_abort_lo", 64'(lo), 64'd0);
      for (int i = 0; i < 6; i++) step();
      read_hilo(hi, lo);
      check_eq("rst_no_late_lo", 64'(lo), 64'd0);
      check_eq("rst_no_late_busy", 64'(bus.out_busy), 64'd0);

      // start and mtlo while busy are ignored; the mult lands on schedule
      start_op(MDU_mult, 32'd5, 32'd6, {32'd0, 32'd30});
      bus.in_mdop  = MDU_div;
      bus.in_num1  = 32'd100;
      bus.in_num2  = 32'd7;
      bus.in_start = 1'b1;
      step();
      bus.in_start = 1'b0;
      bus.in_mdop  = MDU_mtlo;
      bus.in_num1  = 32'h55;
      step();
      bus.in_mdop  = MDU_none;
      wait_done("busy_ignore", 3);
      for (int i = 0; i < 12; i++) step();
      read_hilo(hi, lo);
      check_eq("busy_ignore_late_lo", 64'(lo), 64'd30);
      check_eq("busy_ignore_idle", 64'(bus.out_busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
